fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register directly upstream of the main control decoder. Holds the PC and issues word fetches to instruction memory over a variable-latency request/ready handshake. Captures returned words into the IF/ID register, whose if_id_inst[31:26] drives the decoder's opcode input. Handles hazard stalls, a one-entry skid buffer, and branch/jump redirects (beq, bne, j, jal targets resolved downstream).

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem handshake, one-entry skid buffer
// and the IF/ID pipeline register that feeds the control decoder.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        SKID,
        DRAIN
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc4;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // Redirect outranks everything; a request still in flight must be drained before refetching.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            skid_inst   <= 32'h0;
            skid_pc4    <= 32'h0;
            if_id_inst  <= 32'h0;
            if_id_pc4   <= 32'h0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_pc & 32'hFFFF_FFFC;
            skid_inst   <= 32'h0;
            skid_pc4    <= 32'h0;
            if_id_inst  <= 32'h0;
            if_id_valid <= 1'b0;
            if ((state == REQ || state == DRAIN) && !imem_ready)
                state <= DRAIN;
            else
                state <= REQ;
        end else begin
            case (state)
                BOOT: begin
                    state <= REQ;
                end
                REQ: begin
                    if (imem_ready) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            skid_inst <= imem_rdata;
                            skid_pc4  <= pc_plus4;
                            state     <= SKID;
                        end else begin
                            if_id_inst  <= imem_rdata;
                            if_id_pc4   <= pc_plus4;
                            if_id_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_id_inst  <= 32'h0;
                        if_id_valid <= 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        if_id_inst  <= skid_inst;
                        if_id_pc4   <= skid_pc4;
                        if_id_valid <= 1'b1;
                        state       <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ready)
                        state <= REQ;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the corner cases, then random
// stimulus checked against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .if_id_inst(if_id_inst),
        .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        redir;
        logic [31:0] rpc;
        logic        chk_pre;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } word_t;

    vec_t tbl[$];

    // Reference model: a fetch is in flight unless booting, draining or holding a word.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_drain;
    word_t       m_held[$];
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;

    function automatic bit m_fetching();
        return !m_boot && !m_drain && (m_held.size() == 0);
    endfunction

    function automatic void model_step(logic rst, logic rdy, logic [31:0] rdata,
                                       logic stl, logic redir, logic [31:0] rpc);
        word_t w;
        if (rst) begin
            m_pc = RPC; m_boot = 1; m_drain = 0; m_held.delete();
            m_inst = 0; m_pc4 = 0; m_valid = 0;
        end else if (redir) begin
            m_drain = (m_fetching() || m_drain) && !rdy;
            m_boot  = 0;
            m_pc    = {rpc[31:2], 2'b00};
            m_held.delete();
            m_inst  = 0; m_valid = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_drain) begin
            if (rdy) m_drain = 0;
        end else if (m_held.size() != 0) begin
            if (!stl) begin
                w = m_held.pop_front();
                m_inst = w.inst; m_pc4 = w.pc4; m_valid = 1;
            end
        end else if (rdy) begin
            w.inst = rdata;
            w.pc4  = m_pc + 32'd4;
            m_pc   = w.pc4;
            if (stl) m_held.push_back(w);
            else begin m_inst = w.inst; m_pc4 = w.pc4; m_valid = 1; end
        end else if (!stl) begin
            m_inst = 0; m_valid = 0;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        reset = v.rst; imem_ready = v.rdy; imem_rdata = v.rdata;
        stall = v.stl; redirect = v.redir; redirect_pc = v.rpc;
        if (v.chk_pre) begin
            checkOutput($sformatf("row%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.exp_req});
            checkOutput($sformatf("row%0d imem_addr", idx), imem_addr, v.exp_addr);
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("row%0d if_id_inst", idx), if_id_inst, v.exp_inst);
        checkOutput($sformatf("row%0d if_id_pc4", idx), if_id_pc4, v.exp_pc4);
        checkOutput($sformatf("row%0d if_id_valid", idx), {31'b0, if_id_valid}, {31'b0, v.exp_valid});
    endtask

    function automatic vec_t mk(logic rst, logic rdy, logic [31:0] rdata, logic stl,
                                logic redir, logic [31:0] rpc, logic chk_pre, logic req,
                                logic [31:0] addr, logic [31:0] inst, logic [31:0] pc4, logic valid);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.redir = redir; v.rpc = rpc;
        v.chk_pre = chk_pre; v.exp_req = req; v.exp_addr = addr;
        v.exp_inst = inst; v.exp_pc4 = pc4; v.exp_valid = valid;
        return v;
    endfunction

    initial begin
        reset = 1; imem_ready = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;

        //           rst rdy rdata          stl rdr rpc            pre req addr           inst           pc4            v
        tbl.push_back(mk(1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 0, 32'h0040_0000, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'h0040_0000, 0, 0, 32'h0,         1, 1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1));
        tbl.push_back(mk(0, 1, 32'h0040_0004, 0, 0, 32'h0,         1, 1, 32'h0040_0004, 32'h0040_0004, 32'h0040_0008, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0040_0008, 32'h0,         32'h0040_0008, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0040_0008, 32'h0,         32'h0040_0008, 0));
        tbl.push_back(mk(0, 1, 32'h0040_0008, 0, 0, 32'h0,         1, 1, 32'h0040_0008, 32'h0040_0008, 32'h0040_000C, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 1, 32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 1));
        tbl.push_back(mk(0, 1, 32'h0040_000C, 1, 0, 32'h0,         1, 1, 32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 1));
        tbl.push_back(mk(0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0,         1, 0, 32'h0040_0010, 32'h0040_0008, 32'h0040_000C, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h0040_0010, 32'h0040_0008, 32'h0040_000C, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 1));
        tbl.push_back(mk(0, 1, 32'h0040_0010, 0, 0, 32'h0,         1, 1, 32'h0040_0010, 32'h0040_0010, 32'h0040_0014, 1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0040_0103, 1, 1, 32'h0040_0014, 32'h0,         32'h0040_0014, 0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0040_0100, 32'h0,         32'h0040_0014, 0));
        tbl.push_back(mk(0, 1, 32'h57A1_E000, 0, 0, 32'h0,         1, 0, 32'h0040_0100, 32'h0,         32'h0040_0014, 0));
        tbl.push_back(mk(0, 1, 32'h0040_0100, 0, 0, 32'h0,         1, 1, 32'h0040_0100, 32'h0040_0100, 32'h0040_0104, 1));
        tbl.push_back(mk(0, 1, 32'h0040_0104, 1, 0, 32'h0,         1, 1, 32'h0040_0104, 32'h0040_0100, 32'h0040_0104, 1));
        tbl.push_back(mk(0, 0, 32'h0,         1, 1, 32'h0040_0200, 1, 0, 32'h0040_0108, 32'h0,         32'h0040_0104, 0));
        tbl.push_back(mk(0, 1, 32'h0040_0200, 0, 0, 32'h0,         1, 1, 32'h0040_0200, 32'h0040_0200, 32'h0040_0204, 1));
        tbl.push_back(mk(0, 1, 32'h1111_1111, 0, 1, 32'hFFFF_FFFF, 1, 1, 32'h0040_0204, 32'h0,         32'h0040_0204, 0));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         1));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 32'h0,         32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 1, 32'h0000_1000, 1, 1, 32'h0,         32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0000_1000, 32'h0,         32'h0,         0));
        tbl.push_back(mk(1, 1, 32'h2222_2222, 0, 0, 32'h0,         1, 0, 32'h0000_1000, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h0040_0000, 32'h0,         32'h0,         0));
        tbl.push_back(mk(0, 1, 32'h0040_0000, 0, 0, 32'h0,         1, 1, 32'h0040_0000, 32'h0040_0000, 32'h0040_0004, 1));

        $display("[TB] directed vectors: %0d rows", tbl.size());
        for (int i = 0; i < tbl.size(); i++)
            applyStimulus(tbl[i], i);

        $display("[TB] random phase");
        begin
            bit known = 0;
            for (int c = 0; c < 4000; c++) begin
                logic        r_rst, r_rdy, r_stl, r_redir;
                logic [31:0] r_rdata, r_rpc;
                r_rst   = (c == 0) || ($urandom_range(0, 99) == 0);
                r_rdy   = ($urandom_range(0, 99) < 55);
                r_rdata = $urandom;
                r_stl   = ($urandom_range(0, 99) < 30);
                r_redir = ($urandom_range(0, 99) < 10);
                r_rpc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom;
                @(negedge clk);
                reset = r_rst; imem_ready = r_rdy; imem_rdata = r_rdata;
                stall = r_stl; redirect = r_redir; redirect_pc = r_rpc;
                if (known) begin
                    checkOutput($sformatf("rnd%0d imem_req", c), {31'b0, imem_req}, {31'b0, m_fetching()});
                    checkOutput($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
                end
                model_step(r_rst, r_rdy, r_rdata, r_stl, r_redir, r_rpc);
                if (r_rst) known = 1;
                @(posedge clk);
                #1;
                checkOutput($sformatf("rnd%0d if_id_inst", c), if_id_inst, m_inst);
                checkOutput($sformatf("rnd%0d if_id_pc4", c), if_id_pc4, m_pc4);
                checkOutput($sformatf("rnd%0d if_id_valid", c), {31'b0, if_id_valid}, {31'b0, m_valid});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
